// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the instruction/data cache memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W       = 28;
  localparam int MEM_DATA_W       = 128;
  localparam int WAIT_W           = 4;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the caches-plus-memory view.
interface mem_arbiter_if;

  logic                              i_mem_read;
  logic [mem_arb_pkg::MEM_ADDR_W-1:0] i_mem_addr;
  logic [mem_arb_pkg::MEM_DATA_W-1:0] i_mem_rdata;
  logic                              i_mem_ready;

  logic                              d_mem_read;
  logic                              d_mem_write;
  logic [mem_arb_pkg::MEM_ADDR_W-1:0] d_mem_addr;
  logic [mem_arb_pkg::MEM_DATA_W-1:0] d_mem_wdata;
  logic [mem_arb_pkg::MEM_DATA_W-1:0] d_mem_rdata;
  logic                              d_mem_ready;

  logic                              mem_read;
  logic                              mem_write;
  logic [mem_arb_pkg::MEM_ADDR_W-1:0] mem_addr;
  logic [mem_arb_pkg::MEM_DATA_W-1:0] mem_wdata;
  logic [mem_arb_pkg::MEM_DATA_W-1:0] mem_rdata;
  logic                              mem_ready;

  modport slave (
    input  i_mem_read, i_mem_addr,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  mem_rdata, mem_ready,
    output i_mem_rdata, i_mem_ready,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_mem_read, i_mem_addr,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output mem_rdata, mem_ready,
    input  i_mem_rdata, i_mem_ready,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_value <= '0;
    end else if (i_inc && (r_value != '1)) begin
      r_value <= r_value + WIDTH'(1);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single 128-bit memory port between I-cache and D-cache.
// D-cache has priority up to a starvation limit; MEM_ARB_PERF_EN adds perf counters.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`ifdef MEM_ARB_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             proc_reset,
  mem_arbiter_if.slave     bus
`ifdef MEM_ARB_PERF_EN
  , output logic [CNT_W-1:0] perf_i_cnt
  , output logic [CNT_W-1:0] perf_d_cnt
  , output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  arb_state_t        r_state;
  logic              w_dReq;
  logic              w_iReq;
  logic              w_idle;
  logic              w_starved;
  logic              w_grantD;
  logic              w_grantI;
  logic [WAIT_W-1:0] w_waitCnt;

  assign w_dReq    = bus.d_mem_read | bus.d_mem_write;
  assign w_iReq    = bus.i_mem_read;
  assign w_idle    = (r_state == IDLE);
  assign w_starved = (w_waitCnt == LIMIT);
  // D wins unless I has already been passed over STARVE_LIMIT times in a row.
  assign w_grantD  = w_idle & w_dReq & ~(w_iReq & w_starved);
  assign w_grantI  = w_idle & w_iReq & ~w_grantD;

  sat_counter #(.WIDTH(WAIT_W)) u_waitCnt (
    .clk     (clk),
    .rst     (proc_reset),
    .i_inc   (w_grantD & w_iReq),
    .i_clear (w_idle & (w_grantI | ~w_iReq)),
    .o_value (w_waitCnt)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantD) begin
            r_state <= GRANT_D;
          end else if (w_grantI) begin
            r_state <= GRANT_I;
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.mem_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.i_mem_rdata = bus.mem_rdata;
  assign bus.d_mem_rdata = bus.mem_rdata;

  // Ready is forwarded in the same cycle memory raises it, so outputs decode from state.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.i_mem_ready = 1'b0;
    bus.d_mem_ready = 1'b0;
    case (r_state)
      GRANT_I: begin
        bus.mem_read    = bus.i_mem_read;
        bus.mem_addr    = bus.i_mem_addr;
        bus.i_mem_ready = bus.mem_ready;
      end
      GRANT_D: begin
        bus.mem_write   = bus.d_mem_write;
        bus.mem_read    = bus.d_mem_read & ~bus.d_mem_write;
        bus.mem_addr    = bus.d_mem_addr;
        bus.mem_wdata   = bus.d_mem_wdata;
        bus.d_mem_ready = bus.mem_ready;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  sat_counter #(.WIDTH(CNT_W)) u_perfI (
    .clk     (clk),
    .rst     (proc_reset),
    .i_inc   ((r_state == GRANT_I) & bus.mem_ready),
    .i_clear (1'b0),
    .o_value (perf_i_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_perfD (
    .clk     (clk),
    .rst     (proc_reset),
    .i_inc   ((r_state == GRANT_D) & bus.mem_ready),
    .i_clear (1'b0),
    .o_value (perf_d_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_perfStall (
    .clk     (clk),
    .rst     (proc_reset),
    .i_inc   (w_iReq & (r_state != GRANT_I)),
    .i_clear (1'b0),
    .o_value (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_LIMIT = 4).
// The perf-counter scenario is built only when MEM_ARB_PERF_EN is defined.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic procReset;
  int   checks = 0;
  int   failures = 0;
  int   violationCount = 0;
  logic illegalPrev = 1'b0;

  mem_arbiter_if bus();

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perfICnt;
  logic [15:0] perfDCnt;
  logic [15:0] perfStallCnt;
`endif

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .proc_reset (procReset),
    .bus        (bus)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_cnt     (perfICnt)
    , .perf_d_cnt     (perfDCnt)
    , .perf_stall_cnt (perfStallCnt)
`endif
  );

  always #5 clk = ~clk;

  // Protocol monitor: counts each new episode of D read and write raised together.
  always @(posedge clk) begin
    if (!procReset && bus.d_mem_read && bus.d_mem_write && !illegalPrev) begin
      violationCount <= violationCount + 1;
      $display("[TB] protocol violation: D-cache read and write asserted together");
    end
    illegalPrev <= bus.d_mem_read & bus.d_mem_write;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    procReset        = 1'b1;
    bus.i_mem_read   = 1'b0;
    bus.i_mem_addr   = 28'h1234567;
    bus.d_mem_read   = 1'b0;
    bus.d_mem_write  = 1'b0;
    bus.d_mem_addr   = 28'h7654321;
    bus.d_mem_wdata  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    bus.mem_rdata    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.mem_ready    = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.mem_read !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_mem_read: got %0b expected 0", bus.mem_read);
    end
    checks++;
    if (bus.mem_write !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_mem_write: got %0b expected 0", bus.mem_write);
    end
    checks++;
    if (bus.mem_addr !== 28'h0) begin
      failures++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr);
    end
    checks++;
    if (bus.mem_wdata !== 128'h0) begin
      failures++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata);
    end
    checks++;
    if (bus.i_mem_ready !== 1'b0 || bus.d_mem_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready: got i=%0b d=%0b expected 0/0", bus.i_mem_ready, bus.d_mem_ready);
    end
    checks++;
    if (bus.i_mem_rdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
      failures++; $display("[TB] FAIL i_rdata_passthru: got %h", bus.i_mem_rdata);
    end
    checks++;
    if (bus.d_mem_rdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
      failures++; $display("[TB] FAIL d_rdata_passthru: got %h", bus.d_mem_rdata);
    end
    procReset     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    bus.i_mem_addr = 28'h0000010;
    bus.i_mem_read = 1'b1;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0) begin
      failures++; $display("[TB] FAIL fetch_no_strobe_in_idle: got %0b expected 0", bus.mem_read);
    end
    tick();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fetch_strobe: got rd=%0b wr=%0b expected 1/0", bus.mem_read, bus.mem_write);
    end
    checks++;
    if (bus.mem_addr !== 28'h0000010) begin
      failures++; $display("[TB] FAIL fetch_addr: got %h expected 0000010", bus.mem_addr);
    end
    checks++;
    if (bus.i_mem_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL fetch_early_ready: got %0b expected 0", bus.i_mem_ready);
    end
    tick();
    tick();
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.i_mem_ready !== 1'b1 || bus.d_mem_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fetch_ready: got i=%0b d=%0b expected 1/0", bus.i_mem_ready, bus.d_mem_ready);
    end
    tick();
    bus.mem_ready  = 1'b0;
    bus.i_mem_read = 1'b0;
    #1;
    checks++;
    if (bus.i_mem_ready !== 1'b0 || bus.mem_read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fetch_done_idle: got ready=%0b rd=%0b expected 0/0", bus.i_mem_ready, bus.mem_read);
    end
  endtask

  task automatic test_d_writeback_alloc();
    bus.d_mem_write = 1'b1;
    bus.d_mem_addr  = 28'h00000A0;
    bus.d_mem_wdata = 128'hDEADBEEF_00112233_44556677_8899AABB;
    tick();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wb_strobe: got rd=%0b wr=%0b expected 0/1", bus.mem_read, bus.mem_write);
    end
    checks++;
    if (bus.mem_addr !== 28'h00000A0) begin
      failures++; $display("[TB] FAIL wb_addr: got %h expected 00000a0", bus.mem_addr);
    end
    checks++;
    if (bus.mem_wdata !== 128'hDEADBEEF_00112233_44556677_8899AABB) begin
      failures++; $display("[TB] FAIL wb_wdata: got %h", bus.mem_wdata);
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.d_mem_ready !== 1'b1 || bus.i_mem_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wb_ready: got d=%0b i=%0b expected 1/0", bus.d_mem_ready, bus.i_mem_ready);
    end
    tick();
    bus.mem_ready   = 1'b0;
    bus.d_mem_write = 1'b0;
    bus.d_mem_read  = 1'b1;
    bus.d_mem_addr  = 28'h0000020;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL gap_idle: got rd=%0b wr=%0b expected 0/0", bus.mem_read, bus.mem_write);
    end
    tick();
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0000020) begin
      failures++;
      $display("[TB] FAIL alloc_strobe: got rd=%0b wr=%0b addr=%h expected 1/0/0000020",
               bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.d_mem_read = 1'b0;
    #1;
    checks++;
    if (bus.d_mem_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL alloc_done: got %0b expected 0", bus.d_mem_ready);
    end
  endtask

  task automatic test_starvation();
    bit expI[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [27:0] expAddr;
    bus.i_mem_addr = 28'h0000100;
    bus.i_mem_read = 1'b1;
    bus.d_mem_addr = 28'h0000200;
    bus.d_mem_read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      expAddr = expI[i] ? 28'h0000100 : 28'h0000200;
      checks++;
      if (bus.mem_addr !== expAddr) begin
        failures++; $display("[TB] FAIL starve_grant_%0d: got addr %h expected %h", i, bus.mem_addr, expAddr);
      end
      if (i == 3) begin
        checks++;
        if (dut.w_waitCnt !== 4'd4) begin
          failures++; $display("[TB] FAIL starve_wait_full: got %0d expected 4", dut.w_waitCnt);
        end
      end
      if (i == 4) begin
        checks++;
        if (dut.w_waitCnt !== 4'd0) begin
          failures++; $display("[TB] FAIL starve_wait_clear: got %0d expected 0", dut.w_waitCnt);
        end
      end
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.i_mem_ready !== expI[i] || bus.d_mem_ready !== !expI[i]) begin
        failures++;
        $display("[TB] FAIL starve_ready_%0d: got i=%0b d=%0b expected %0b/%0b",
                 i, bus.i_mem_ready, bus.d_mem_ready, expI[i], !expI[i]);
      end
      tick();
      bus.mem_ready = 1'b0;
    end
    bus.i_mem_read = 1'b0;
    bus.d_mem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bus.d_mem_read = 1'b1;
    bus.d_mem_addr = 28'h0000030;
    tick();
    checks++;
    if (bus.mem_read !== 1'b1) begin
      failures++; $display("[TB] FAIL midreset_granted: got %0b expected 1", bus.mem_read);
    end
    procReset = 1'b1;
    tick();
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_strobes: got rd=%0b wr=%0b expected 0/0", bus.mem_read, bus.mem_write);
    end
    procReset      = 1'b0;
    bus.d_mem_read = 1'b0;
    bus.mem_ready  = 1'b1;
    #1;
    checks++;
    if (bus.i_mem_ready !== 1'b0 || bus.d_mem_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_late_ready: got i=%0b d=%0b expected 0/0", bus.i_mem_ready, bus.d_mem_ready);
    end
    tick();
    checks++;
    if (bus.i_mem_ready !== 1'b0 || bus.d_mem_ready !== 1'b0 || bus.mem_read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_stays_idle: got i=%0b d=%0b rd=%0b expected 0/0/0",
               bus.i_mem_ready, bus.d_mem_ready, bus.mem_read);
    end
    bus.mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_illegal_rw();
    int startCount;
    startCount      = violationCount;
    bus.d_mem_read  = 1'b1;
    bus.d_mem_write = 1'b1;
    bus.d_mem_addr  = 28'h0000040;
    bus.d_mem_wdata = 128'h5555_5555_5555_5555_AAAA_AAAA_AAAA_AAAA;
    tick();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL illegal_write_wins: got rd=%0b wr=%0b expected 0/1", bus.mem_read, bus.mem_write);
    end
    checks++;
    if (violationCount !== startCount + 1) begin
      failures++;
      $display("[TB] FAIL illegal_flagged: got %0d violations expected %0d", violationCount, startCount + 1);
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.d_mem_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL illegal_ready: got %0b expected 1", bus.d_mem_ready);
    end
    tick();
    bus.mem_ready   = 1'b0;
    bus.d_mem_read  = 1'b0;
    bus.d_mem_write = 1'b0;
    tick();
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    procReset = 1'b1;
    tick();
    procReset = 1'b0;
    #1;
    checks++;
    if (perfICnt !== 16'd0 || perfDCnt !== 16'd0 || perfStallCnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL perf_reset: got i=%0d d=%0d stall=%0d expected 0/0/0", perfICnt, perfDCnt, perfStallCnt);
    end
    // I and D together: I waits at the decision edge, through the D grant, and at its own decision edge.
    bus.i_mem_addr = 28'h0000300;
    bus.i_mem_read = 1'b1;
    bus.d_mem_addr = 28'h0000400;
    bus.d_mem_read = 1'b1;
    tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.d_mem_read = 1'b0;
    tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready  = 1'b0;
    bus.i_mem_read = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.i_mem_read = 1'b1;
      tick();
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready  = 1'b0;
      bus.i_mem_read = 1'b0;
    end
    bus.d_mem_write = 1'b1;
    tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready   = 1'b0;
    bus.d_mem_write = 1'b0;
    #1;
    checks++;
    if (perfICnt !== 16'd3) begin
      failures++; $display("[TB] FAIL perf_i_cnt: got %0d expected 3", perfICnt);
    end
    checks++;
    if (perfDCnt !== 16'd2) begin
      failures++; $display("[TB] FAIL perf_d_cnt: got %0d expected 2", perfDCnt);
    end
    checks++;
    if (perfStallCnt !== 16'd5) begin
      failures++; $display("[TB] FAIL perf_stall_cnt: got %0d expected 5", perfStallCnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting mem_arbiter bench");
    test_reset();
    test_single_fetch();
    test_d_writeback_alloc();
    test_starvation();
    test_reset_mid_grant();
    test_illegal_rw();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit memory port between the read-only instruction cache and the read/write data cache.
- Sits between both cache memory interfaces and the memory model/controller.
- Grants one whole transaction at a time. The data cache has fixed priority, with a starvation limit that protects instruction fetch.
- Requesters hold request level, address and write data stable until they see their ready.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive D-cache grants while an I-cache request is pending; legal range 1..15.
- CNT_W, 16: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock
- proc_reset  in  1  synchronous active-high reset
- i_mem_read  in  1  I-cache fetch request (level)
- i_mem_addr  in  28  I-cache block address
- i_mem_rdata  out  128  block data to I-cache
- i_mem_ready  out  1  I-cache transaction done
- d_mem_read  in  1  D-cache allocate request (level)
- d_mem_write  in  1  D-cache write-back request (level)
- d_mem_addr  in  28  D-cache block address
- d_mem_wdata  in  128  D-cache write-back data
- d_mem_rdata  out  128  block data to D-cache
- d_mem_ready  out  1  D-cache transaction done
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  28  memory block address
- mem_wdata  out  128  memory write data
- mem_rdata  in  128  memory read data
- mem_ready  in  1  memory transaction done

Behaviour:
- State register: IDLE, GRANT_I, GRANT_D. Reset state is IDLE; reset clears wait_cnt and the performance counters.
- Reset values, all outputs (IDLE drives these; outputs decode combinationally from state):
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - i_mem_ready = 0, d_mem_ready = 0.
  - i_mem_rdata = mem_rdata and d_mem_rdata = mem_rdata at all times. The data lines are qualified only by the matching ready.
- Request signals: d_req = d_mem_read | d_mem_write; i_req = i_mem_read.
- IDLE decision, made every cycle:
  - Only d_req -> GRANT_D.
  - Only i_req -> GRANT_I.
  - Both requesting -> GRANT_I if wait_cnt == STARVE_LIMIT, else GRANT_D.
  - Neither requesting -> stay in IDLE.
- wait_cnt update, applied at the IDLE decision edge:
  - Increment when D is granted while i_req = 1.
  - Clear when I is granted or when i_req = 0.
  - Saturates at STARVE_LIMIT.
- GRANT_I:
  - mem_read = i_mem_read; mem_addr = i_mem_addr; mem_write = 0.
  - i_mem_ready = mem_ready; d_mem_ready = 0.
- GRANT_D:
  - mem_write = d_mem_write; mem_read = d_mem_read & ~d_mem_write; mem_addr = d_mem_addr; mem_wdata = d_mem_wdata.
  - d_mem_ready = mem_ready; i_mem_ready = 0.
- In a GRANT state, mem_ready = 1 -> IDLE on the next edge. There is no back-to-back grant, so there is always at least one IDLE cycle between transactions. This lets the requester drop its level after seeing ready.
- Latency: request seen in IDLE at cycle N -> memory strobe in cycle N+1 -> ready forwarded in the same cycle memory raises it (zero added latency on the return path).
- Boundary conditions:
  - Granted requester drops its request before ready: strobes fall to 0; the arbiter stays in the GRANT state until mem_ready. This is a protocol violation, flagged by the bench assertion.
  - D-cache asserts read and write together: write wins, read is masked; protocol violation, flagged by assertion.
  - Non-granted requester: its ready stays 0 for the whole transaction of the other requester.
  - Reset during a GRANT state: IDLE on that edge, so strobes are 0 from the next cycle. Any in-flight memory transaction is abandoned.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_i_cnt, perf_d_cnt and perf_stall_cnt, each CNT_W wide and out.
  - perf_i_cnt and perf_d_cnt increment on each completed transaction (ready & grant).
  - perf_stall_cnt increments each cycle i_req = 1 and state != GRANT_I.
  - All three saturate at all-ones and reset to 0.
- Undefined: the ports and registers do not exist; arbitration behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (2-bit: IDLE = 0, GRANT_I = 1, GRANT_D = 2);
  - MEM_ADDR_W = 28 and MEM_DATA_W = 128;
  - the default STARVE_LIMIT.
- Sub-module sat_counter (parameter width, inc, clear, value), reused for wait_cnt and the perf counters.
- Grant decode and output muxing stay in the top module.

Test Plan:
1. Single I fetch: i_mem_read = 1, addr 0x0000010, memory ready after 3 cycles -> mem_read rises cycle+1 with mem_addr = 0x0000010; i_mem_ready pulses 1 cycle; d_mem_ready stays 0.
2. D write-back then allocate: d_mem_write addr 0x00000A0, wdata 0xDEADBEEF_..., then d_mem_read addr 0x0000020 -> mem_write only during the first grant, one IDLE cycle, then mem_read with addr 0x0000020.
3. Simultaneous requests, STARVE_LIMIT = 4, D re-requesting continuously -> grants follow D, D, D, D, I, D...; wait_cnt returns to 0 after the I grant.
4. Reset asserted in GRANT_D mid-transaction -> next cycle mem_read = mem_write = 0 and state IDLE; a later mem_ready produces no ready pulse to either cache.
5. Illegal D read+write together -> mem_write = 1, mem_read = 0; assertion fires.
6. With MEM_ARB_PERF_EN: 3 I and 2 D transactions -> perf_i_cnt = 3, perf_d_cnt = 2; perf_stall_cnt equals the cycles I waited.
